// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the fetch queue: slot geometry, NOP encoding and the
// 196-bit bundle layout stored in each FIFO entry.
package if_fetch_queue_pkg;

  localparam int SLOT_W = 16;
  localparam int SLOTS  = 4;
  localparam int KW     = $clog2(SLOTS);
  localparam logic [SLOT_W-1:0] NOP_INST = 16'h0000;

  typedef struct packed {
    logic [SLOTS*SLOT_W-1:0] pc;
    logic [SLOTS*SLOT_W-1:0] inst;
    logic [SLOTS*SLOT_W-1:0] recv;
    logic [SLOTS-1:0]        pred;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Bubble seen by IF/ID whenever there is no valid work to hand over.
  function automatic fetch_entry_t bubble_entry();
    fetch_entry_t e;
    e      = '0;
    e.inst = {SLOTS{NOP_INST}};
    return e;
  endfunction

endpackage

// File: rtl/fetch_pred_mask.sv
// Turns the per-slot predicted-taken bits into the index of the first taken
// slot, the slot-valid mask and the one-hot prediction result.
module fetch_pred_mask
  import if_fetch_queue_pkg::*;
(
  input  logic [SLOTS-1:0] bp_taken,
  output logic [KW-1:0]    k,
  output logic             taken_any,
  output logic [SLOTS-1:0] slot_valid,
  output logic [SLOTS-1:0] slot_pred
);

  logic found;

  always_comb begin
    k          = '0;
    found      = 1'b0;
    taken_any  = |bp_taken;
    slot_valid = '0;
    slot_pred  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (bp_taken[i] && !found) begin
        k     = KW'(i);
        found = 1'b1;
      end
    end
    // Slots after the first taken branch are on the wrong path.
    for (int i = 0; i < SLOTS; i++) begin
      slot_valid[i] = !taken_any || (KW'(i) <= k);
      slot_pred[i]  = taken_any && (KW'(i) == k);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: owns the fetch PC, builds 4-slot bundles from imem and the
// branch predictor, and buffers them in a small FIFO ahead of IF/ID.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [PC_W-1:0]         flush_pc,
  output logic [PC_W-1:0]         imem_addr,
  output logic                    imem_en,
  input  logic [SLOTS*SLOT_W-1:0] imem_rdata,
  input  logic [SLOTS-1:0]        bp_taken,
  input  logic [PC_W-1:0]         bp_target,
  output logic [SLOTS*SLOT_W-1:0] pc_to_dec,
  output logic [SLOTS*SLOT_W-1:0] inst_to_dec,
  output logic [SLOTS*SLOT_W-1:0] recv_pc_to_dec,
  output logic [SLOTS-1:0]        pred_result_to_dec,
  output logic                    fq_full,
  output logic                    fq_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [PC_W-1:0] pc_q;
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            push;
  logic            pop;

  fetch_entry_t    mem [DEPTH];
  fetch_entry_t    new_entry;
  fetch_entry_t    out_entry;

  logic [KW-1:0]    k;
  logic             taken_any;
  logic [SLOTS-1:0] slot_valid;
  logic [SLOTS-1:0] slot_pred;

  fetch_pred_mask u_pred_mask (
    .bp_taken   (bp_taken),
    .k          (k),
    .taken_any  (taken_any),
    .slot_valid (slot_valid),
    .slot_pred  (slot_pred)
  );

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign fq_empty  = (wr_ptr == rd_ptr);
  assign fq_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = ~stall & ~fq_empty & ~flush;
  assign push      = ~flush & (~fq_full | pop);
  assign imem_en   = push;
  assign imem_addr = pc_q;

  always_comb begin
    new_entry = '0;
    for (int i = 0; i < SLOTS; i++) begin
      new_entry.pc[i*SLOT_W +: SLOT_W]   = pc_q + PC_W'(i);
      new_entry.inst[i*SLOT_W +: SLOT_W] = slot_valid[i] ? imem_rdata[i*SLOT_W +: SLOT_W]
                                                         : NOP_INST;
      new_entry.recv[i*SLOT_W +: SLOT_W] = slot_pred[i] ? (pc_q + PC_W'(k) + PC_W'(1))
                                                        : '0;
      new_entry.pred[i]                  = slot_pred[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      pc_q   <= flush_pc;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        pc_q   <= taken_any ? bp_target : pc_q + PC_W'(SLOTS);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Data storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= new_entry;
    end
  end

  // A flush forces a bubble so IF/ID never latches wrong-path work.
  assign out_entry = (fq_empty || flush) ? bubble_entry() : mem[rd_ptr[AW-1:0]];

  assign pc_to_dec          = out_entry.pc;
  assign inst_to_dec        = out_entry.inst;
  assign recv_pc_to_dec     = out_entry.recv;
  assign pred_result_to_dec = out_entry.pred;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue with a combinational imem
// model whose word at address a is a + 16'h1000.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [15:0] flush_pc;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [63:0] imem_rdata;
  logic [3:0]  bp_taken;
  logic [15:0] bp_target;
  logic [63:0] pc_to_dec;
  logic [63:0] inst_to_dec;
  logic [63:0] recv_pc_to_dec;
  logic [3:0]  pred_result_to_dec;
  logic        fq_full;
  logic        fq_empty;

  int checks = 0;
  int passed = 0;

  if_fetch_queue #(.DEPTH(4), .PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .stall              (stall),
    .flush              (flush),
    .flush_pc           (flush_pc),
    .imem_addr          (imem_addr),
    .imem_en            (imem_en),
    .imem_rdata         (imem_rdata),
    .bp_taken           (bp_taken),
    .bp_target          (bp_target),
    .pc_to_dec          (pc_to_dec),
    .inst_to_dec        (inst_to_dec),
    .recv_pc_to_dec     (recv_pc_to_dec),
    .pred_result_to_dec (pred_result_to_dec),
    .fq_full            (fq_full),
    .fq_empty           (fq_empty)
  );

  always #5 clk = ~clk;

  always_comb begin
    imem_rdata = '0;
    for (int i = 0; i < 4; i++) imem_rdata[16*i +: 16] = imem_addr + 16'(i) + 16'h1000;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0; bp_taken = '0; bp_target = '0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    checks++; if (fq_empty !== 1'b1) $display("[TB] FAIL rst_empty: got %b want 1", fq_empty); else passed++;
    checks++; if (fq_full !== 1'b0) $display("[TB] FAIL rst_full: got %b want 0", fq_full); else passed++;
    checks++; if (imem_addr !== 16'h0000) $display("[TB] FAIL rst_addr: got %h want 0000", imem_addr); else passed++;
    checks++; if (imem_en !== 1'b1) $display("[TB] FAIL rst_en: got %b want 1", imem_en); else passed++;
    checks++; if (pc_to_dec !== 64'h0) $display("[TB] FAIL rst_bubble_pc: got %h want 0", pc_to_dec); else passed++;
    checks++; if (inst_to_dec !== 64'h0) $display("[TB] FAIL rst_bubble_inst: got %h want 0", inst_to_dec); else passed++;
  endtask

  task automatic test_sequential_fetch();
    step();
    checks++; if (imem_addr !== 16'h0004) $display("[TB] FAIL seq_addr4: got %h want 0004", imem_addr); else passed++;
    checks++; if (pc_to_dec !== 64'h0003_0002_0001_0000) $display("[TB] FAIL seq_pc0: got %h want 0003000200010000", pc_to_dec); else passed++;
    checks++; if (inst_to_dec !== 64'h1003_1002_1001_1000) $display("[TB] FAIL seq_inst0: got %h want 1003100210011000", inst_to_dec); else passed++;
    checks++; if (pred_result_to_dec !== 4'b0000) $display("[TB] FAIL seq_pred0: got %b want 0000", pred_result_to_dec); else passed++;
    step();
    checks++; if (imem_addr !== 16'h0008) $display("[TB] FAIL seq_addr8: got %h want 0008", imem_addr); else passed++;
    checks++; if (pc_to_dec !== 64'h0007_0006_0005_0004) $display("[TB] FAIL seq_pc4: got %h want 0007000600050004", pc_to_dec); else passed++;
  endtask

  task automatic test_branch_mask();
    bp_taken = 4'b0110; bp_target = 16'h0040;
    step();
    bp_taken = 4'b0000;
    #1;
    checks++; if (pred_result_to_dec !== 4'b0010) $display("[TB] FAIL br_pred: got %b want 0010", pred_result_to_dec); else passed++;
    checks++; if (inst_to_dec !== 64'h0000_0000_1009_1008) $display("[TB] FAIL br_inst: got %h want 0000000010091008", inst_to_dec); else passed++;
    checks++; if (recv_pc_to_dec !== 64'h0000_0000_000A_0000) $display("[TB] FAIL br_recv: got %h want 00000000000a0000", recv_pc_to_dec); else passed++;
    checks++; if (pc_to_dec !== 64'h000B_000A_0009_0008) $display("[TB] FAIL br_pc: got %h want 000b000a00090008", pc_to_dec); else passed++;
    checks++; if (imem_addr !== 16'h0040) $display("[TB] FAIL br_target: got %h want 0040", imem_addr); else passed++;
  endtask

  task automatic test_stall_fill();
    stall = 1'b1;
    repeat (6) step();
    checks++; if (fq_full !== 1'b1) $display("[TB] FAIL st_full: got %b want 1", fq_full); else passed++;
    checks++; if (imem_en !== 1'b0) $display("[TB] FAIL st_en: got %b want 0", imem_en); else passed++;
    checks++; if (imem_addr !== 16'h004C) $display("[TB] FAIL st_addr: got %h want 004c", imem_addr); else passed++;
    checks++; if (pc_to_dec !== 64'h000B_000A_0009_0008) $display("[TB] FAIL st_hold: got %h want 000b000a00090008", pc_to_dec); else passed++;
    stall = 1'b0;
    #1;
    checks++; if (imem_en !== 1'b1) $display("[TB] FAIL st_release_en: got %b want 1", imem_en); else passed++;
    step();
    checks++; if (fq_full !== 1'b1) $display("[TB] FAIL st_still_full: got %b want 1", fq_full); else passed++;
    checks++; if (pc_to_dec !== 64'h0043_0042_0041_0040) $display("[TB] FAIL st_next_head: got %h want 0043004200410040", pc_to_dec); else passed++;
    checks++; if (imem_addr !== 16'h0050) $display("[TB] FAIL st_addr50: got %h want 0050", imem_addr); else passed++;
  endtask

  task automatic test_flush();
    stall = 1'b1; flush_pc = 16'h0123; flush = 1'b1;
    #1;
    checks++; if (pc_to_dec !== 64'h0) $display("[TB] FAIL fl_bubble_pc: got %h want 0", pc_to_dec); else passed++;
    checks++; if (inst_to_dec !== 64'h0) $display("[TB] FAIL fl_bubble_inst: got %h want 0", inst_to_dec); else passed++;
    checks++; if (imem_en !== 1'b0) $display("[TB] FAIL fl_en: got %b want 0", imem_en); else passed++;
    step();
    flush = 1'b0;
    #1;
    checks++; if (fq_empty !== 1'b1) $display("[TB] FAIL fl_empty: got %b want 1", fq_empty); else passed++;
    checks++; if (imem_addr !== 16'h0123) $display("[TB] FAIL fl_addr: got %h want 0123", imem_addr); else passed++;
    stall = 1'b0;
  endtask

  task automatic test_pc_wrap();
    flush_pc = 16'hFFFE; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checks++; if (imem_addr !== 16'hFFFE) $display("[TB] FAIL wr_addr: got %h want fffe", imem_addr); else passed++;
    step();
    checks++; if (pc_to_dec !== 64'h0001_0000_FFFF_FFFE) $display("[TB] FAIL wr_pc: got %h want 00010000fffffffe", pc_to_dec); else passed++;
    checks++; if (inst_to_dec !== 64'h1001_1000_0FFF_0FFE) $display("[TB] FAIL wr_inst: got %h want 100110000fff0ffe", inst_to_dec); else passed++;
    checks++; if (imem_addr !== 16'h0002) $display("[TB] FAIL wr_next: got %h want 0002", imem_addr); else passed++;
  endtask

  task automatic test_pred_edges();
    bp_taken = 4'b0001; bp_target = 16'h0200;
    step();
    bp_taken = 4'b1000; bp_target = 16'h0300;
    #1;
    checks++; if (pred_result_to_dec !== 4'b0001) $display("[TB] FAIL k0_pred: got %b want 0001", pred_result_to_dec); else passed++;
    checks++; if (inst_to_dec !== 64'h0000_0000_0000_1002) $display("[TB] FAIL k0_inst: got %h want 0000000000001002", inst_to_dec); else passed++;
    checks++; if (recv_pc_to_dec !== 64'h0000_0000_0000_0003) $display("[TB] FAIL k0_recv: got %h want 0000000000000003", recv_pc_to_dec); else passed++;
    checks++; if (imem_addr !== 16'h0200) $display("[TB] FAIL k0_target: got %h want 0200", imem_addr); else passed++;
    step();
    bp_taken = 4'b0000;
    #1;
    checks++; if (pred_result_to_dec !== 4'b1000) $display("[TB] FAIL k3_pred: got %b want 1000", pred_result_to_dec); else passed++;
    checks++; if (inst_to_dec !== 64'h1203_1202_1201_1200) $display("[TB] FAIL k3_inst: got %h want 1203120212011200", inst_to_dec); else passed++;
    checks++; if (recv_pc_to_dec !== 64'h0204_0000_0000_0000) $display("[TB] FAIL k3_recv: got %h want 0204000000000000", recv_pc_to_dec); else passed++;
    checks++; if (imem_addr !== 16'h0300) $display("[TB] FAIL k3_target: got %h want 0300", imem_addr); else passed++;
  endtask

  task automatic test_mid_reset();
    stall = 1'b1;
    repeat (2) step();
    checks++; if (fq_full !== 1'b0 || fq_empty !== 1'b0) $display("[TB] FAIL mr_partial: got full=%b empty=%b want full=0 empty=0", fq_full, fq_empty); else passed++;
    checks++; if (imem_addr !== 16'h0308) $display("[TB] FAIL mr_addr_pre: got %h want 0308", imem_addr); else passed++;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (fq_empty !== 1'b1) $display("[TB] FAIL mr_empty: got %b want 1", fq_empty); else passed++;
    checks++; if (imem_addr !== 16'h0000) $display("[TB] FAIL mr_addr: got %h want 0000", imem_addr); else passed++;
    checks++; if (pc_to_dec !== 64'h0 || recv_pc_to_dec !== 64'h0 || pred_result_to_dec !== 4'b0)
      $display("[TB] FAIL mr_bubble: got pc=%h recv=%h pred=%b want all zero", pc_to_dec, recv_pc_to_dec, pred_result_to_dec);
    else passed++;
    stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential_fetch();
    test_branch_mask();
    test_stall_fill();
    test_flush();
    test_pc_wrap();
    test_pred_edges();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
